// File: rtl/silencer_sequencer.sv
// rtl/silencer_sequencer.sv - tick generation, source addressing and start/done control for one silencer
// Optional external sync ticks: define SEQ_EXT_SYNC_EN (adds SYNC_IN, SYNC_MISS).
module silencer_sequencer #(
    parameter int WIDTH        = 13,
    parameter int DEPTH        = 249,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [15:0]      UPDATE_INTERVAL,
    input  logic [WIDTH-1:0] STEP_IN,
    input  logic             CFG_LOAD,
    output logic [7:0]       SRC_ADDR,
    output logic             SRC_EN,
    output logic             SIL_DIN_VALID,
    output logic [WIDTH-1:0] SIL_STEP,
    input  logic             SIL_DOUT_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic [15:0]      OVERRUN_CNT,
    output logic             TIMEOUT_ERR,
    input  logic             ERR_CLR
`ifdef SEQ_EXT_SYNC_EN
    ,
    input  logic             SYNC_IN,
    output logic             SYNC_MISS
`endif
);

    localparam int LIMIT = DEPTH + 9 + TIMEOUT;
    localparam int WD_W  = $clog2(LIMIT + 1);
    localparam int OC_W  = $clog2(DEPTH + 1);

    localparam logic [7:0]      LAST_ADDR  = 8'(DEPTH - 1);
    localparam logic [OC_W-1:0] OUT_ALL    = OC_W'(DEPTH);
    localparam logic [WD_W-1:0] WD_EXPIRE  = WD_W'(LIMIT - 1);
    localparam logic [WD_W-1:0] WD_MAX     = WD_W'(LIMIT);
    localparam logic [1:0]      FETCH_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             tick;
    logic [7:0]       addr_d;
    logic             en_d;
    logic             din_valid_d;
    logic [WIDTH-1:0] step_d;
    logic             busy_d;
    logic             done_d;
    logic [15:0]      overrun_d;
    logic             timeout_err_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic [OC_W-1:0]  out_cnt_q;
    logic [OC_W-1:0]  out_cnt_d;
    logic [WD_W-1:0]  wd_q;
    logic [WD_W-1:0]  wd_d;
    logic [1:0]       fetch_cnt_q;
    logic [1:0]       fetch_cnt_d;

`ifdef SEQ_EXT_SYNC_EN
    // Two synchroniser flops plus one history flop for rising-edge detection.
    logic [2:0] sync_q;
    logic       unused_interval;

    assign unused_interval = ^UPDATE_INTERVAL;
    assign tick            = sync_q[1] & ~sync_q[2];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q    <= '0;
            SYNC_MISS <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], SYNC_IN};
            SYNC_MISS <= tick & BUSY;
        end
    end
`else
    logic [15:0] period_cnt_q;
    logic [15:0] period_len_q;

    assign tick = (period_len_q != 16'd0) && (period_cnt_q == period_len_q - 16'd1);

    // A zero period re-samples every cycle so a newly programmed interval takes effect at once.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            period_cnt_q <= '0;
            period_len_q <= '0;
        end else if (period_len_q == 16'd0 || tick) begin
            period_cnt_q <= '0;
            period_len_q <= UPDATE_INTERVAL;
        end else begin
            period_cnt_q <= period_cnt_q + 16'd1;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = SRC_ADDR;
        en_d          = SRC_EN;
        din_valid_d   = 1'b0;
        step_d        = SIL_STEP;
        busy_d        = BUSY;
        done_d        = 1'b0;
        overrun_d     = OVERRUN_CNT;
        timeout_err_d = TIMEOUT_ERR;
        shadow_d      = CFG_LOAD ? STEP_IN : shadow_q;
        out_cnt_d     = out_cnt_q;
        wd_d          = wd_q;
        fetch_cnt_d   = fetch_cnt_q;

        // Address stream runs on its own once started; it parks on the last index.
        if (SRC_EN) begin
            if (SRC_ADDR == LAST_ADDR) begin
                en_d = 1'b0;
            end else begin
                addr_d = SRC_ADDR + 8'd1;
            end
        end

        if (state_q == S_RUN || state_q == S_DRAIN) begin
            if (wd_q != WD_MAX) begin
                wd_d = wd_q + WD_W'(1);
            end
            if (SIL_DOUT_VALID && out_cnt_q != OUT_ALL) begin
                out_cnt_d = out_cnt_q + OC_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d     = S_FETCH;
                    addr_d      = 8'd0;
                    en_d        = 1'b1;
                    busy_d      = 1'b1;
                    step_d      = CFG_LOAD ? STEP_IN : shadow_q;
                    out_cnt_d   = '0;
                    wd_d        = '0;
                    fetch_cnt_d = '0;
                end
            end
            S_FETCH: begin
                fetch_cnt_d = fetch_cnt_q + 2'd1;
                if (fetch_cnt_q == FETCH_LAST) begin
                    din_valid_d = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (!SRC_EN || SRC_ADDR == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == OUT_ALL) begin
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end else if (wd_q >= WD_EXPIRE) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_GAP;
                end
            end
            S_GAP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tick && state_q != S_IDLE && OVERRUN_CNT != 16'hFFFF) begin
            overrun_d = OVERRUN_CNT + 16'd1;
        end

        if (ERR_CLR) begin
            overrun_d     = '0;
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            SRC_ADDR      <= '0;
            SRC_EN        <= 1'b0;
            SIL_DIN_VALID <= 1'b0;
            SIL_STEP      <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            OVERRUN_CNT   <= '0;
            TIMEOUT_ERR   <= 1'b0;
            shadow_q      <= '0;
            out_cnt_q     <= '0;
            wd_q          <= '0;
            fetch_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            SRC_ADDR      <= addr_d;
            SRC_EN        <= en_d;
            SIL_DIN_VALID <= din_valid_d;
            SIL_STEP      <= step_d;
            BUSY          <= busy_d;
            DONE          <= done_d;
            OVERRUN_CNT   <= overrun_d;
            TIMEOUT_ERR   <= timeout_err_d;
            shadow_q      <= shadow_d;
            out_cnt_q     <= out_cnt_d;
            wd_q          <= wd_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end

endmodule

// File: doc/silencer_sequencer.md
Name: silencer_sequencer

Overview:
- Controller that sequences one silencer datapath instance.
- Generates periodic update ticks and streams transducer indices 0..DEPTH-1 to the duty/phase source memory, timed so each DUTY/PHASE word arrives on the silencer inputs in the exact cycle it is sampled.
- Issues the silencer start pulse with a stable shadowed STEP, counts returned outputs, and reports done, overrun and timeout.
- Sits between the modulation/STM source memories and the silencer.

Parameters:
- WIDTH, 13, duty/phase/step width
- DEPTH, 249, transducers per update
- READ_LATENCY, 1, source memory read latency in cycles (1..3)
- TIMEOUT, 16, extra cycles allowed beyond DEPTH+9 for outputs to complete

Ports:
- CLK  in  1  clock
- RST_N  in  1  synchronous active-low reset
- UPDATE_INTERVAL  in  16  tick period in CLK cycles; 0 = ticks disabled
- STEP_IN  in  WIDTH  step configuration
- CFG_LOAD  in  1  pulse: latch STEP_IN into shadow register
- SRC_ADDR  out  8  source memory index
- SRC_EN  out  1  source read enable
- SIL_DIN_VALID  out  1  silencer start pulse
- SIL_STEP  out  WIDTH  step presented to the silencer
- SIL_DOUT_VALID  in  1  silencer output-valid strobe
- BUSY  out  1  update in progress
- DONE  out  1  one-cycle pulse: update complete
- OVERRUN_CNT  out  16  saturating count of dropped ticks
- TIMEOUT_ERR  out  1  sticky timeout flag
- ERR_CLR  in  1  clears TIMEOUT_ERR and OVERRUN_CNT

Behaviour:
- Reset (RST_N=0 at a CLK edge) forces all of the following on the next cycle:
  - state IDLE; all outputs 0; shadow step 0; period counter 0.
  - Reset mid-update abandons the update; no DONE is generated.
- Period counter:
  - Counts 0..UPDATE_INTERVAL-1, wraps to 0 and asserts an internal tick in the wrap cycle.
  - UPDATE_INTERVAL is re-sampled only at wrap.
  - UPDATE_INTERVAL = 0 holds the counter at 0 with no ticks.
- States: IDLE, FETCH, RUN, DRAIN, GAP.
- IDLE:
  - On tick, go to FETCH.
  - Set addr=0, SRC_EN=1, BUSY=1.
  - Copy the shadow step to SIL_STEP; SIL_STEP stays frozen until the next start.
- FETCH:
  - SRC_ADDR increments each cycle.
  - After READ_LATENCY cycles, assert SIL_DIN_VALID for exactly one cycle (cycle t0) and go to RUN.
  - Index k is driven in cycle t0-READ_LATENCY+k, so data for index k appears on the silencer DUTY/PHASE inputs in cycle t0+k.
- RUN:
  - Addressing continues until SRC_ADDR = DEPTH-1 has been driven.
  - Then SRC_EN=0, SRC_ADDR holds DEPTH-1, and the state goes to DRAIN.
- Output counting (FETCH/RUN/DRAIN):
  - An output counter counts SIL_DOUT_VALID cycles from t0.
  - A watchdog counts cycles from t0.
- DRAIN:
  - When the output count reaches DEPTH: pulse DONE, then go to GAP.
  - If the watchdog reaches DEPTH+9+TIMEOUT first: set TIMEOUT_ERR, go to GAP, no DONE.
  - SIL_DOUT_VALID seen after count = DEPTH is ignored.
- GAP:
  - One cycle; BUSY=0 on exit; then IDLE.
  - Guarantees the silencer is back in its waiting state before the next start.
- Overrun:
  - A tick arriving in FETCH/RUN/DRAIN/GAP is dropped.
  - OVERRUN_CNT increments, saturating at 0xFFFF.
  - The update starts on the next tick seen in IDLE; ticks are never queued.
- CFG_LOAD:
  - Updates the shadow register only.
  - CFG_LOAD in the same cycle as the IDLE->FETCH transition: the new STEP_IN is used for that update (write-through).
- ERR_CLR:
  - Priority over a same-cycle increment or set; the event in that cycle is lost.

Optional Feature:
- Macro SEQ_EXT_SYNC_EN.
- Defined:
  - Adds input SYNC_IN (1 bit). Ticks are rising edges of SYNC_IN (registered, 2-flop synchronised); UPDATE_INTERVAL is ignored.
  - Adds output SYNC_MISS, a one-cycle pulse whenever an edge arrives while BUSY.
- Undefined:
  - Internal period counter only; neither port exists.

Test Plan:
- Reset then UPDATE_INTERVAL=1000, CFG_LOAD with STEP_IN=10, READ_LATENCY=1:
  - SRC_ADDR=0 one cycle before SIL_DIN_VALID; SIL_STEP=10; addresses 0..248 consecutive.
  - DONE after 249 SIL_DOUT_VALID; next start 1000 cycles after the first.
- UPDATE_INTERVAL=200 (< update length):
  - Every second tick dropped; OVERRUN_CNT increments by 1 per dropped tick.
  - ERR_CLR returns it to 0.
- Silencer model stops strobing after 100 outputs:
  - TIMEOUT_ERR=1 at t0+274; no DONE; next tick starts a clean update.
- CFG_LOAD STEP_IN=50 mid-RUN:
  - SIL_STEP stays 10 until the next SIL_DIN_VALID, then 50.
  - CFG_LOAD coincident with the tick: new value used immediately.
- RST_N=0 for 1 cycle at address 120:
  - Next cycle all outputs 0, state IDLE, no DONE.
  - UPDATE_INTERVAL=0 afterwards: no SIL_DIN_VALID ever.
- SEQ_EXT_SYNC_EN: SYNC_IN edges 100 cycles apart:
  - One update per accepted edge; SYNC_MISS pulses for edges during BUSY.
